// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and load/store.
// Data has fixed priority; a starvation counter forces a fetch after STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  IReq,
  input  logic [ADDR_W-1:0]     IAdr,
  output logic [DATA_W-1:0]     IRData,
  output logic                  IReady,
  input  logic                  DReq,
  input  logic                  DWrite,
  input  logic [ADDR_W-1:0]     DAdr,
  input  logic [DATA_W-1:0]     DWData,
  input  logic [DATA_W/8-1:0]   DByteEn,
  output logic [DATA_W-1:0]     DRData,
  output logic                  DReady,
  output logic                  BusReq,
  output logic                  BusWrite,
  output logic [ADDR_W-1:0]     BusAdr,
  output logic [DATA_W-1:0]     BusWData,
  output logic [DATA_W/8-1:0]   BusByteEn,
  input  logic                  BusAck,
  input  logic [DATA_W-1:0]     BusRData,
  output logic                  Busy
);

  localparam int unsigned BeW = DATA_W / 8;
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                resp_data_q, resp_data_d;
  logic                bus_write_q, bus_write_d;
  logic [ADDR_W-1:0]   bus_adr_q, bus_adr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [BeW-1:0]      bus_be_q, bus_be_d;
  logic [DATA_W-1:0]   irdata_q, irdata_d;
  logic [DATA_W-1:0]   drdata_q, drdata_d;
  logic                data_win;

  // Data wins unless fetch is pending and has already been passed over STARVE_MAX times.
  assign data_win = DReq && !(IReq && (starve_cnt_q == StarveMax));

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    resp_data_d  = resp_data_q;
    bus_write_d  = bus_write_q;
    bus_adr_d    = bus_adr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;

    unique case (state_q)
      StIdle: begin
        if (data_win) begin
          state_d     = StData;
          resp_data_d = 1'b1;
          bus_write_d = DWrite;
          bus_adr_d   = DAdr;
          bus_wdata_d = DWData;
          bus_be_d    = DByteEn;
          if (IReq) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = 4'd0;
          end
        end else if (IReq) begin
          state_d      = StFetch;
          resp_data_d  = 1'b0;
          bus_write_d  = 1'b0;
          bus_adr_d    = IAdr;
          bus_wdata_d  = '0;
          bus_be_d     = '1;
          starve_cnt_d = 4'd0;
        end
      end
      StFetch, StData: begin
        if (BusAck) begin
          state_d = StResp;
          if (state_q == StFetch) begin
            irdata_d = BusRData;
          end else if (!bus_write_q) begin
            drdata_d = BusRData;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= 4'd0;
      resp_data_q  <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_adr_q    <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      irdata_q     <= '0;
      drdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      resp_data_q  <= resp_data_d;
      bus_write_q  <= bus_write_d;
      bus_adr_q    <= bus_adr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
    end
  end

  assign BusReq    = (state_q == StFetch) || (state_q == StData);
  assign Busy      = (state_q != StIdle);
  assign IReady    = (state_q == StResp) && !resp_data_q;
  assign DReady    = (state_q == StResp) && resp_data_q;
  assign BusWrite  = bus_write_q;
  assign BusAdr    = bus_adr_q;
  assign BusWData  = bus_wdata_q;
  assign BusByteEn = bus_be_q;
  assign IRData    = irdata_q;
  assign DRData    = drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IReq, DReq, DWrite, BusAck;
  logic [31:0] IAdr, DAdr, DWData, BusRData;
  logic [3:0]  DByteEn;
  logic [31:0] IRData, DRData, BusAdr, BusWData;
  logic [3:0]  BusByteEn;
  logic        IReady, DReady, BusReq, BusWrite, Busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .IReq     (IReq),
    .IAdr     (IAdr),
    .IRData   (IRData),
    .IReady   (IReady),
    .DReq     (DReq),
    .DWrite   (DWrite),
    .DAdr     (DAdr),
    .DWData   (DWData),
    .DByteEn  (DByteEn),
    .DRData   (DRData),
    .DReady   (DReady),
    .BusReq   (BusReq),
    .BusWrite (BusWrite),
    .BusAdr   (BusAdr),
    .BusWData (BusWData),
    .BusByteEn(BusByteEn),
    .BusAck   (BusAck),
    .BusRData (BusRData),
    .Busy     (Busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE with requests already driven; walks grant, wait states, ack, RESP, IDLE.
  task automatic serve(input string tag, input bit is_d, input logic [31:0] adr,
                       input logic we, input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] rdata, input logic [31:0] exp_rd, input int nwait);
    step();
    for (int i = 0; i <= nwait; i++) begin
      check({tag, ".busreq"}, BusReq, 1);
      check({tag, ".busadr"}, BusAdr, adr);
      check({tag, ".buswrite"}, BusWrite, we);
      check({tag, ".busbe"}, BusByteEn, be);
      check({tag, ".buswdata"}, BusWData, wd);
      check({tag, ".ready_early"}, {IReady, DReady}, 0);
      if (i == nwait) begin
        BusAck   = 1'b1;
        BusRData = rdata;
      end
      step();
    end
    BusAck   = 1'b0;
    BusRData = 32'hBAD0_BAD0;
    check({tag, ".iready"}, IReady, !is_d);
    check({tag, ".dready"}, DReady, is_d);
    check({tag, ".resp_busreq"}, BusReq, 0);
    check({tag, ".resp_busy"}, Busy, 1);
    check({tag, ".rdata"}, is_d ? DRData : IRData, exp_rd);
    step();
    check({tag, ".idle_busy"}, Busy, 0);
    check({tag, ".idle_ready"}, {IReady, DReady}, 0);
    check({tag, ".rdata_hold"}, is_d ? DRData : IRData, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string pat;
    reset_n = 1'b0;
    IReq = 0; DReq = 0; DWrite = 0; BusAck = 0;
    IAdr = '0; DAdr = '0; DWData = '0; BusRData = '0; DByteEn = '0;
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    check("rst.busreq", BusReq, 0);
    check("rst.busy", Busy, 0);
    check("rst.ready", {IReady, DReady}, 0);
    check("rst.rdata", {IRData, DRData}, 0);
    check("rst.bus", {BusWrite, BusByteEn, BusAdr}, 0);
    check("rst.starve", dut.starve_cnt_q, 0);

    // 1. Fetch only, ack in first BusReq cycle
    IReq = 1; IAdr = 32'h100;
    serve("t1", 0, 32'h100, 0, 4'hF, 0, 32'h0050_0093, 32'h0050_0093, 0);
    IReq = 0;

    // 2. Store with three wait states; DRData untouched
    DReq = 1; DWrite = 1; DAdr = 32'h2004; DWData = 32'hDEAD_BEEF; DByteEn = 4'h3;
    serve("t2", 1, 32'h2004, 1, 4'h3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 3);
    DReq = 0; DWrite = 0;

    // 3. Simultaneous requests: data first, then fetch
    IReq = 1; IAdr = 32'h104; DReq = 1; DAdr = 32'h3000; DByteEn = 4'hF; DWData = 32'h55;
    check("t3.starve0", dut.starve_cnt_q, 0);
    serve("t3d", 1, 32'h3000, 0, 4'hF, 32'h55, 32'hAAAA_0001, 32'hAAAA_0001, 0);
    DReq = 0;
    check("t3.starve1", dut.starve_cnt_q, 1);
    serve("t3i", 0, 32'h104, 0, 4'hF, 0, 32'h0000_0013, 32'h0000_0013, 0);
    IReq = 0;
    check("t3.starve_clr", dut.starve_cnt_q, 0);

    // 4. Both held: D,D,D,D,I,D with starve counter 0,1,2,3,4,0
    IReq = 1; IAdr = 32'h200; DReq = 1; DAdr = 32'h4000; DWData = 32'h77;
    pat = "DDDDID";
    begin
      logic [3:0] exp_cnt [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      for (int g = 0; g < 6; g++) begin
        check($sformatf("t4.starve%0d", g), dut.starve_cnt_q, exp_cnt[g]);
        if (pat[g] == "D") begin
          serve($sformatf("t4g%0d", g), 1, 32'h4000, 0, 4'hF, 32'h77,
                32'hC000_0000 + g, 32'hC000_0000 + g, 0);
        end else begin
          serve($sformatf("t4g%0d", g), 0, 32'h200, 0, 4'hF, 0,
                32'hF000_0000 + g, 32'hF000_0000 + g, 0);
        end
      end
    end
    check("t4.starve_end", dut.starve_cnt_q, 1);
    IReq = 0; DReq = 0;

    // 5. Reset while in DATA, then a stray ack
    DReq = 1; DAdr = 32'h5000;
    step();
    check("t5.busreq", BusReq, 1);
    reset_n = 1'b0;
    step();
    check("t5.rst_busreq", BusReq, 0);
    check("t5.rst_busy", Busy, 0);
    check("t5.rst_ready", {IReady, DReady}, 0);
    reset_n = 1'b1; DReq = 0; BusAck = 1; BusRData = 32'h1111_2222;
    step();
    BusAck = 0;
    check("t5.stray_busy", Busy, 0);
    check("t5.stray_ready", DReady, 0);
    check("t5.stray_rdata", DRData, 0);
    step();
    check("t5.stray_busy2", Busy, 0);
    check("t5.starve_rst", dut.starve_cnt_q, 0);

    // 6. Load with DReq held through RESP, dropped on seeing DReady
    DReq = 1; DWrite = 0; DAdr = 32'h6008;
    serve("t6", 1, 32'h6008, 0, 4'hF, 32'h77, 32'h0BAD_F00D, 32'h0BAD_F00D, 0);
    DReq = 0;
    step();
    check("t6.no_regrant_busreq", BusReq, 0);
    check("t6.no_regrant_busy", Busy, 0);
    check("t6.no_second_ready", DReady, 0);
    check("t6.rdata_final", DRData, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
